vga_plot_arbiter: RTL
=====================

# vga_plot_arbiter

Shares the single VGA adapter plot port between three box-drawing requesters: the track-clear sequencer and the two player drawers. Each granted request paints one BOX_W x BOX_H box of a single colour, one pixel per cycle, then acknowledges the requester. The block sits between the game-logic FSMs and the vga_adapter instance in the top level.

## Interface
- BOX_W, 5: box width in pixels, 1..8
- BOX_H, 3: box height in pixels, 1..8
- clk  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-low reset
- clr_req  in  1  clear-sequencer request; held until clr_ack
- clr_x  in  8  clear box top-left x
- clr_y  in  7  clear box top-left y
- clr_colour  in  3  clear box colour
- clr_ack  out  1  one-cycle pulse when the clear box is complete
- p1_req, p1_x, p1_y, p1_colour, p1_ack: same widths and meaning for player 1
- p2_req, p2_x, p2_y, p2_colour, p2_ack: same widths and meaning for player 2
- vga_x  out  8  pixel x to adapter
- vga_y  out  7  pixel y to adapter
- vga_colour  out  3  pixel colour to adapter
- plot  out  1  adapter write enable
- busy  out  1  high in DRAW and DONE

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: if any req is high, pick a winner, latch its x, y and colour into base registers, clear cx and cy, and go to DRAW. Otherwise stay in IDLE.
- Priority: clr_req always wins. Between p1 and p2, see Configuration.
- DRAW: plot=1. vga_x = base_x + cx, truncated to 8 bits (mod 256). vga_y = base_y + cy, truncated to 7 bits (mod 128). vga_colour = latched colour.
- Scan order is x-fastest. cx increments each cycle. When cx = BOX_W-1, cx returns to 0 and cy increments. When cx = BOX_W-1 and cy = BOX_H-1, go to DONE.
- DONE: plot=0. Pulse the ack of the granted requester for exactly one cycle, then go to IDLE.
- Requester inputs are sampled only in IDLE. Changes to x, y, colour or req during DRAW or DONE are ignored.
- A requester must drop req in the cycle after it sees ack. A req still high in the following IDLE cycle is treated as a new request.
- All outputs are functions of registered state only. There is no combinational path from any input to any output.
- Reset values: state=IDLE; plot, busy and all acks 0; vga_x, vga_y, vga_colour, cx and cy 0; round-robin pointer set to favour p1.
- resetn low in any state, including mid-box: at the next edge go to IDLE with reset values. The partial box is abandoned and no ack is issued.

## Timing
- req high in IDLE cycle T: plot is high for cycles T+1 .. T+BOX_W*BOX_H, ack is high in cycle T+BOX_W*BOX_H+1, and the block is back in IDLE at T+BOX_W*BOX_H+2.
- Back-to-back throughput: one box every BOX_W*BOX_H+2 cycles (17 cycles at the defaults).
- Arbitration decision happens in IDLE only. The winner is fixed for the whole box.
- Simultaneous requests in one IDLE cycle: exactly one grant; the losers keep req high and wait.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: p1 and p2 alternate. A 1-bit pointer toggles to favour the other player after each player grant. Clear grants do not change the pointer.
- Undefined: fixed priority, with p1 always beating p2. No pointer register is built.

## Test plan
- Single request. p1_req=1, x=38, y=3, colour=3'b010 at IDLE -> 15 plot cycles covering (38..42, 3..5) in x-fastest order, then one p1_ack pulse, then plot=0.
- Clear priority. clr_req and p1_req high together, clr_x=118, clr_y=97, colour=3'b111 -> clear box (118..122, 97..99) drawn first, clr_ack, then the p1 box; p1_ack arrives 17 cycles after clr_ack.
- p1/p2 contention with ARB_ROUND_ROBIN_EN defined. p1 and p2 held high across three boxes -> grant order p1, p2, p1.
- p1/p2 contention with ARB_ROUND_ROBIN_EN undefined. Same stimulus -> p2 is granted only after p1_req drops.
- Wrap-around. p2 x=254, y=126 -> vga_x sequence 254, 255, 0, 1, 2 and vga_y values 126, 127, 0; no ack to any other requester.
- Reset mid-box. resetn=0 on the 7th DRAW cycle of a p1 box -> next cycle plot=0, busy=0, vga_x=0, no p1_ack; after release, a held p1_req is re-granted starting from pixel (x, y).

Source files
------------

// File: rtl/vga_plot_arbiter.sv
//------------------------------------------------------------------------------
// Module   : vga_plot_arbiter
// Purpose  : Grants the shared VGA plot port to one of three box-drawing requesters
//            and paints that requester's box, one pixel per cycle.
// Options  : ARB_ROUND_ROBIN_EN - alternate p1/p2 instead of p1 fixed priority
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_plot_arbiter #(
    parameter int BOX_W = 5,
    parameter int BOX_H = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr_req,
    input  logic [7:0] clr_x,
    input  logic [6:0] clr_y,
    input  logic [2:0] clr_colour,
    output logic       clr_ack,
    input  logic       p1_req,
    input  logic [7:0] p1_x,
    input  logic [6:0] p1_y,
    input  logic [2:0] p1_colour,
    output logic       p1_ack,
    input  logic       p2_req,
    input  logic [7:0] p2_x,
    input  logic [6:0] p2_y,
    input  logic [2:0] p2_colour,
    output logic       p2_ack,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] C_GNT_CLR = 2'd0;
    localparam logic [1:0] C_GNT_P1  = 2'd1;
    localparam logic [1:0] C_GNT_P2  = 2'd2;
    localparam logic [2:0] C_LAST_X  = 3'(BOX_W - 1);
    localparam logic [2:0] C_LAST_Y  = 3'(BOX_H - 1);

    state_t     state_q;
    logic [7:0] base_x_q;
    logic [6:0] base_y_q;
    logic [2:0] cx_q, cy_q;
    logic [2:0] cx_d, cy_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] vga_x_q, sel_x_d;
    logic [6:0] vga_y_q, sel_y_d;
    logic [2:0] vga_colour_q, sel_colour_d;
    logic       plot_q, busy_q;
    logic       clr_ack_q, p1_ack_q, p2_ack_q;
    logic       w_any_req;
    logic       w_p1_first;
    logic       w_last_x;
    logic       w_box_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q;  // 1 means p2 is favoured on the next p1/p2 tie
    assign w_p1_first = ~rr_q;
`else
    assign w_p1_first = 1'b1;
`endif

    assign w_any_req = clr_req | p1_req | p2_req;

    always_comb begin
        grant_d      = C_GNT_CLR;
        sel_x_d      = clr_x;
        sel_y_d      = clr_y;
        sel_colour_d = clr_colour;
        if (!clr_req) begin
            if (p1_req && (!p2_req || w_p1_first)) begin
                grant_d      = C_GNT_P1;
                sel_x_d      = p1_x;
                sel_y_d      = p1_y;
                sel_colour_d = p1_colour;
            end else begin
                grant_d      = C_GNT_P2;
                sel_x_d      = p2_x;
                sel_y_d      = p2_y;
                sel_colour_d = p2_colour;
            end
        end
    end

    // x-fastest scan; cy only advances when cx wraps
    assign w_last_x   = (cx_q == C_LAST_X);
    assign w_box_done = w_last_x && (cy_q == C_LAST_Y);
    assign cx_d       = w_last_x ? 3'd0 : cx_q + 3'd1;
    assign cy_d       = w_last_x ? cy_q + 3'd1 : cy_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            base_x_q     <= 8'd0;
            base_y_q     <= 7'd0;
            cx_q         <= 3'd0;
            cy_q         <= 3'd0;
            grant_q      <= C_GNT_CLR;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            clr_ack_q    <= 1'b0;
            p1_ack_q     <= 1'b0;
            p2_ack_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q         <= 1'b0;
`endif
        end else begin
            clr_ack_q <= 1'b0;
            p1_ack_q  <= 1'b0;
            p2_ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_any_req) begin
                        base_x_q     <= sel_x_d;
                        base_y_q     <= sel_y_d;
                        vga_x_q      <= sel_x_d;
                        vga_y_q      <= sel_y_d;
                        vga_colour_q <= sel_colour_d;
                        cx_q         <= 3'd0;
                        cy_q         <= 3'd0;
                        grant_q      <= grant_d;
                        plot_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_DRAW;
`ifdef ARB_ROUND_ROBIN_EN
                        if (grant_d == C_GNT_P1) begin
                            rr_q <= 1'b1;
                        end else if (grant_d == C_GNT_P2) begin
                            rr_q <= 1'b0;
                        end
`endif
                    end
                end
                S_DRAW: begin
                    if (w_box_done) begin
                        plot_q  <= 1'b0;
                        state_q <= S_DONE;
                        case (grant_q)
                            C_GNT_CLR: clr_ack_q <= 1'b1;
                            C_GNT_P1:  p1_ack_q  <= 1'b1;
                            default:   p2_ack_q  <= 1'b1;
                        endcase
                    end else begin
                        cx_q    <= cx_d;
                        cy_q    <= cy_d;
                        vga_x_q <= base_x_q + {5'd0, cx_d};
                        vga_y_q <= base_y_q + {4'd0, cy_d};
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign clr_ack    = clr_ack_q;
    assign p1_ack     = p1_ack_q;
    assign p2_ack     = p2_ack_q;

endmodule

`default_nettype wire
